// File: rtl/edge_detect_pkg.sv
// rtl/edge_detect_pkg.sv - mode encodings and event qualification for edge_detect_mc
package edge_detect_pkg;

    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t EDGE_OFF  = 2'b00;
    localparam edge_mode_t EDGE_RISE = 2'b01;
    localparam edge_mode_t EDGE_FALL = 2'b10;
    localparam edge_mode_t EDGE_BOTH = 2'b11;

    function automatic logic edge_event(input edge_mode_t mode, input logic rise, input logic fall);
        logic ev;
        ev = 1'b0;
        case (mode)
            EDGE_OFF:  ev = 1'b0;
            EDGE_RISE: ev = rise;
            EDGE_FALL: ev = fall;
            EDGE_BOTH: ev = rise | fall;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/edge_detect_mc_if.sv
// rtl/edge_detect_mc_if.sv - channel inputs, per-channel mode/clear and edge/status outputs
interface edge_detect_mc_if #(
    parameter int CH = 4
);
    logic [CH-1:0]   din;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   posEdge;
    logic [CH-1:0]   negEdge;
    logic [CH-1:0]   dualEdge;
    logic [CH-1:0]   status;
    logic            irq;

    modport master (
        output din, mode, clr,
        input  posEdge, negEdge, dualEdge, status, irq
    );

    modport slave (
        input  din, mode, clr,
        output posEdge, negEdge, dualEdge, status, irq
    );
endinterface

// File: rtl/edge_chan.sv
// rtl/edge_chan.sv - one channel: synchroniser, optional glitch filter (EDGE_DETECT_FILT_EN), edge pulses, sticky status
module edge_chan
    import edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef EDGE_DETECT_FILT_EN
    , parameter int FILT_CNT = 3
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_i,
    input  edge_mode_t mode_i,
    input  logic       clr_i,
    input  logic       armed_i,
    output logic       pos_o,
    output logic       neg_o,
    output logic       dual_o,
    output logic       status_o,
    output logic       status_d_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_out;
    logic                   lvl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
        end
    end

    assign s_out = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DETECT_FILT_EN
    localparam int CW = $clog2(FILT_CNT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;

    // Counter only runs while the synchronised input disagrees with the accepted level.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (s_out != lvl_q) begin
            if (cnt_q == CW'(FILT_CNT - 1)) begin
                lvl_d = s_out;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign lvl = lvl_q;
`else
    assign lvl = s_out;
`endif

    logic prev_q, pos_q, neg_q, dual_q, status_q;
    logic pos_d, neg_d, status_d;

    // prev follows lvl even while disarmed, so a level present at reset release never looks like an edge.
    always_comb begin
        pos_d    = armed_i & lvl & ~prev_q;
        neg_d    = armed_i & ~lvl & prev_q;
        status_d = edge_event(mode_i, pos_d, neg_d) | (status_q & ~clr_i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q   <= 1'b0;
            pos_q    <= 1'b0;
            neg_q    <= 1'b0;
            dual_q   <= 1'b0;
            status_q <= 1'b0;
        end else begin
            prev_q   <= lvl;
            pos_q    <= pos_d;
            neg_q    <= neg_d;
            dual_q   <= pos_d | neg_d;
            status_q <= status_d;
        end
    end

    assign pos_o      = pos_q;
    assign neg_o      = neg_q;
    assign dual_o     = dual_q;
    assign status_o   = status_q;
    assign status_d_o = status_d;

endmodule

// File: rtl/edge_detect_mc.sv
// rtl/edge_detect_mc.sv - multi-channel edge detector top: arm counter, channel array, irq (filter via EDGE_DETECT_FILT_EN)
module edge_detect_mc
    import edge_detect_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CNT    = 3
) (
    input  logic             clk,
    input  logic             rst,
    edge_detect_mc_if.slave  bus
);

`ifdef EDGE_DETECT_FILT_EN
    localparam int ARM_CYC = SYNC_STAGES + FILT_CNT + 1;
`else
    localparam int ARM_CYC = SYNC_STAGES + 1;
`endif
    // Sized for the longer (filtered) window so both builds share one counter width.
    localparam int ARM_W = $clog2(SYNC_STAGES + FILT_CNT + 2);

    logic [ARM_W-1:0] arm_q, arm_d;
    logic             armed;

    assign armed = (arm_q == ARM_W'(ARM_CYC));
    assign arm_d = armed ? arm_q : arm_q + 1'b1;

    logic [CH-1:0] pos, neg, dual, status, status_d;
    logic          irq_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arm_q <= '0;
            irq_q <= 1'b0;
        end else begin
            arm_q <= arm_d;
            irq_q <= |status_d;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES)
`ifdef EDGE_DETECT_FILT_EN
            , .FILT_CNT  (FILT_CNT)
`endif
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .din_i      (bus.din[i]),
            .mode_i     (bus.mode[2*i +: 2]),
            .clr_i      (bus.clr[i]),
            .armed_i    (armed),
            .pos_o      (pos[i]),
            .neg_o      (neg[i]),
            .dual_o     (dual[i]),
            .status_o   (status[i]),
            .status_d_o (status_d[i])
        );
    end

    assign bus.posEdge  = pos;
    assign bus.negEdge  = neg;
    assign bus.dualEdge = dual;
    assign bus.status   = status;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_edge_detect_mc.sv
// tb/tb_edge_detect_mc.sv - self-checking bench for edge_detect_mc (filter tests under EDGE_DETECT_FILT_EN)
module tb_edge_detect_mc;

    localparam int CH   = 4;
    localparam int S    = 2;
    localparam int F    = 3;
    localparam int MAXT = 4096;
`ifdef EDGE_DETECT_FILT_EN
    localparam int ARM  = S + F + 1;
`else
    localparam int ARM  = S + 1;
`endif

    logic clk, rst;
    edge_detect_mc_if #(.CH(CH)) bus ();

    edge_detect_mc #(.CH(CH), .SYNC_STAGES(S), .FILT_CNT(F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: din sampled at edge t after release, lvl seen in the cycle after edge t.
    logic [CH-1:0] dh [0:MAXT];
    logic [CH-1:0] lv [0:MAXT];
    int            t = 0;
    logic [CH-1:0] pos_m = '0, neg_m = '0, st_m = '0, ev_m;
    logic          irq_m = 1'b0;

    function automatic logic [CH-1:0] din_at(input int k);
        if (k <= 0) return '0;
        return dh[k];
    endfunction

    function automatic logic [CH-1:0] lvl_at(input int k);
        if (k <= 0) return '0;
        return lv[k];
    endfunction

    function automatic logic [CH-1:0] model_lvl(input int k);
`ifdef EDGE_DETECT_FILT_EN
        logic [CH-1:0] old, r, smp;
        logic          flip;
        old = lvl_at(k - 1);
        r   = old;
        for (int i = 0; i < CH; i++) begin
            flip = 1'b1;
            for (int j = 0; j < F; j++) begin
                smp = din_at(k - S - j);
                if (smp[i] == old[i]) flip = 1'b0;
            end
            if (flip) r[i] = ~old[i];
        end
        return r;
`else
        return din_at(k - S + 1);
`endif
    endfunction

    initial begin
        logic [1:0] m;
        forever begin
            @(posedge clk);
            if (!rst) begin
                t = 0; pos_m = '0; neg_m = '0; st_m = '0; irq_m = 1'b0;
            end else if (t < MAXT) begin
                t++;
                dh[t] = bus.din;
                lv[t] = model_lvl(t);
                if (t > ARM) begin
                    pos_m = lvl_at(t - 1) & ~lvl_at(t - 2);
                    neg_m = ~lvl_at(t - 1) & lvl_at(t - 2);
                end else begin
                    pos_m = '0;
                    neg_m = '0;
                end
                for (int i = 0; i < CH; i++) begin
                    m = bus.mode[2*i +: 2];
                    ev_m[i] = (m == 2'b01 && pos_m[i]) || (m == 2'b10 && neg_m[i]) ||
                              (m == 2'b11 && (pos_m[i] || neg_m[i]));
                end
                st_m  = ev_m | (st_m & ~bus.clr);
                irq_m = |st_m;
            end
            #3;
            chk("mon_posEdge",  bus.posEdge,  pos_m);
            chk("mon_negEdge",  bus.negEdge,  neg_m);
            chk("mon_dualEdge", bus.dualEdge, pos_m | neg_m);
            chk("mon_status",   bus.status,   st_m);
            chk("mon_irq",      bus.irq,      irq_m);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0]  seen;
        logic [20:0] pat;
        int          cnt;

        rst = 1'b0;
        bus.din  = 4'hF;
        bus.mode = 8'b11_01_00_01;
        bus.clr  = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_pos",    bus.posEdge,  0);
        chk("rst_neg",    bus.negEdge,  0);
        chk("rst_dual",   bus.dualEdge, 0);
        chk("rst_status", bus.status,   0);
        chk("rst_irq",    bus.irq,      0);

        // Input high through reset release: no rising edge, no status.
        rst  = 1'b1;
        seen = '0;
        repeat (12) begin
            @(posedge clk); #2;
            seen |= bus.posEdge | bus.status;
        end
        chk("t1_no_pos_no_status", seen, 0);
        @(negedge clk); bus.din = 4'h0;
        repeat (8) @(negedge clk);
        bus.clr = 4'hF;
        @(negedge clk); bus.clr = 4'h0;
        repeat (2) @(negedge clk);
        chk("t1_cleared", bus.status, 0);

        // Channel 0 rise then fall, mode rise-only.
        bus.din[0] = 1'b1;
        @(posedge clk);
        @(posedge clk); #2; chk("t2_pos_e0p1", bus.posEdge[0], 0);
        @(posedge clk); #2; chk("t2_pos_e0p2", bus.posEdge[0], 1);
        chk("t2_status0", bus.status[0], 1);
        chk("t2_irq", bus.irq, 1);
        @(posedge clk); #2; chk("t2_pos_e0p3", bus.posEdge[0], 0);
        @(negedge clk); bus.din[0] = 1'b0;
        @(posedge clk); @(posedge clk);
        @(posedge clk); #2; chk("t2_neg_e0p2", bus.negEdge[0], 1);
        chk("t2_status0_kept", bus.status[0], 1);
        @(negedge clk); bus.clr[0] = 1'b1;
        @(negedge clk); bus.clr[0] = 1'b0;
        @(negedge clk);

        // Channel 1 off: pulses but no status.
        pat  = 21'b001100101100010011010;
        cnt  = 0;
        seen = '0;
        for (int i = 20; i >= 0; i--) begin
            @(negedge clk); bus.din[1] = pat[i];
            @(posedge clk); #2;
            cnt += int'(bus.dualEdge[1]);
            seen[0] |= bus.status[1] | bus.irq;
        end
        repeat (4) begin
            @(posedge clk); #2;
            cnt += int'(bus.dualEdge[1]);
            seen[0] |= bus.status[1] | bus.irq;
        end
        chk("t3_dual_count", cnt, 12);
        chk("t3_status_irq", seen, 0);

        // Channel 2: set and clear on the same edge, set wins.
        @(negedge clk); bus.din[2] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); bus.clr[2] = 1'b1;
        @(posedge clk); #2; chk("t4_set_wins", bus.status[2], 1);
        chk("t4_irq_set", bus.irq, 1);
        @(posedge clk); #2; chk("t4_cleared", bus.status[2], 0);
        chk("t4_irq_clr", bus.irq, 0);
        @(negedge clk); bus.clr[2] = 1'b0;

`ifdef EDGE_DETECT_FILT_EN
        // Two-cycle glitch is rejected, three-cycle level is accepted.
        @(negedge clk); bus.din[0] = 1'b1;
        @(negedge clk);
        @(negedge clk); bus.din[0] = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #2;
            cnt += int'(bus.posEdge[0]);
        end
        chk("t5_glitch_rejected", cnt, 0);
        @(negedge clk); bus.din[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); bus.din[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #2; chk("t5_pos_e0p4", bus.posEdge[0], 0);
        @(posedge clk); #2; chk("t5_pos_e0p5", bus.posEdge[0], 1);
`else
        // Channel 3 toggling every cycle keeps dualEdge high throughout.
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); bus.din[3] = ~bus.din[3];
            @(posedge clk); #2;
            cnt += int'(bus.dualEdge[3]);
        end
        repeat (4) begin
            @(posedge clk); #2;
            cnt += int'(bus.dualEdge[3]);
        end
        chk("t5_toggle_dual", cnt, 8);
`endif

        // Build status 1011, then reset asynchronously mid-cycle.
        @(negedge clk);
        bus.mode = 8'b11_01_01_01;
        bus.din  = 4'h0;
        repeat (10) @(negedge clk);
        bus.clr = 4'hF;
        @(negedge clk); bus.clr = 4'h0;
        repeat (2) @(negedge clk);
        bus.din = 4'b1011;
        repeat (9) @(negedge clk);
        @(posedge clk); #2;
        chk("t6_status_1011", bus.status, 4'b1011);
        #3; rst = 1'b0;
        #1;
        chk("t6_async_pos",    bus.posEdge,  0);
        chk("t6_async_dual",   bus.dualEdge, 0);
        chk("t6_async_status", bus.status,   0);
        chk("t6_async_irq",    bus.irq,      0);
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        seen = '0;
        repeat (ARM + 6) begin
            @(posedge clk); #2;
            seen |= bus.posEdge | bus.dualEdge | bus.status;
        end
        chk("t6_quiet_after_rearm", seen, 0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/edge_detect_mc.md
# edge_detect_mc

Multi-channel, parametrised edge detector with input synchronisation, optional glitch filtering, a per-channel edge mode and sticky event status with interrupt. It replaces the single-channel edge detector in designs that sample groups of asynchronous inputs, such as buttons, external strobes and GPIO, and feeds a local interrupt controller.

## Interface
- `CH`, 4: number of independent channels.
- `SYNC_STAGES`, 2: synchroniser flops per channel, legal range 2..4.
- `FILT_CNT`, 3: stable cycles required before the filtered level changes. Used only with the filter macro; legal range ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `din` in CH: asynchronous channel inputs.
- `mode` in 2*CH: per-channel mode. Channel i uses bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
- `clr` in CH: write-1-to-clear pulse for `status`.
- `posEdge` out CH: one-cycle rising-edge pulse. Not gated by `mode`.
- `negEdge` out CH: one-cycle falling-edge pulse. Not gated by `mode`.
- `dualEdge` out CH: `posEdge | negEdge`, registered.
- `status` out CH: sticky event flags.
- `irq` out 1: registered OR of `status`.

## Operation
- **Per-channel pipeline:**
  - Synchroniser chain of `SYNC_STAGES` flops produces `s_out`.
  - The optional filter turns `s_out` into `lvl`.
  - A `prev` register holds `lvl` delayed by 1 cycle.
- **Edge pulses:** `posEdge <= lvl & ~prev`, `negEdge <= ~lvl & prev`, `dualEdge <= lvl ^ prev`. All are registered and high for exactly one cycle per edge.
- **Event qualification:**
  - mode 01: event = rising edge.
  - mode 10: event = falling edge.
  - mode 11: event = either edge.
  - mode 00: no event. Pulses still appear on `posEdge`/`negEdge`/`dualEdge`.
- **Status:** set on the cycle the event pulse asserts, cleared by `clr[i]`. If set and clear occur in the same cycle, **set wins**.
- **irq:** `irq <= |status_next`. It stays high until every flag is cleared.
- **Arming after reset:**
  - An arm counter suppresses pulses and status sets for the first `SYNC_STAGES+1` cycles after `rst` deasserts.
  - `prev` tracks `lvl` throughout, so an input already high at reset release produces no spurious rising edge.
  - With the filter compiled in, the suppression window is `SYNC_STAGES+FILT_CNT+1` cycles.
- **Mode changes:** take effect on the next edge. Existing status is unaffected.

## Timing
- **Reset values:** all outputs 0. Synchroniser flops, `lvl`, `prev`, filter counters and the arm counter are also 0.
- **Reset mid-operation:** asynchronous assertion clears everything immediately. Arming restarts on deassertion.
- **Latency without filter:** `din` first sampled at edge E0 gives `posEdge`/`negEdge`/`dualEdge`/`status` high after edge E0+SYNC_STAGES. `irq` follows at the same edge, because it is computed from the next-state status.
- **Latency with filter:** `FILT_CNT` cycles are added.
- **Pulse width:** with no filter, `din` pulses shorter than 1 clk may be missed. There is no guaranteed minimum behaviour for pulses below 1 cycle.
- **Back-to-back toggling:** a toggle every cycle yields alternating `posEdge`/`negEdge` pulses each cycle (filter disabled). `dualEdge` is held high continuously.

## Configuration
- Macro: `EDGE_DETECT_FILT_EN`.
- **Defined:**
  - Per-channel counter of width $clog2(FILT_CNT+1).
  - The counter resets to 0 whenever `s_out == lvl`, otherwise increments.
  - When it reaches `FILT_CNT`, `lvl <= s_out` and the counter resets to 0.
  - Glitches shorter than `FILT_CNT` cycles are rejected.
- **Not defined:** `lvl = s_out` directly. No counter logic is synthesised.

## Structure
- **Package `edge_detect_pkg`:**
  - Mode constants `EDGE_OFF`=2'b00, `EDGE_RISE`=2'b01, `EDGE_FALL`=2'b10, `EDGE_BOTH`=2'b11.
  - Helper function for event qualification.
- **Sub-module `edge_chan`:** one channel, containing synchroniser, filter, prev, pulses and status bit. It is instantiated `CH` times in a generate loop.
- **Top level:** holds the arm counter and `irq`.

## Test plan
- **Reset with din high:** hold `din`=4'b1111 through reset, release `rst` → no `posEdge` and `status`=0 for all time.
- **Rise and fall, mode 01 on channel 0:**
  - Drive `din[0]` 0→1 → `posEdge[0]` pulses for 1 cycle at E0+2, then `status[0]`=1 and `irq`=1.
  - Drive `din[0]` 1→0 → `negEdge[0]` pulses and `status[0]` is unchanged.
- **Mode 00 on channel 1:** drive the sequence 21'b001100101100010011010 on `din[1]` → `dualEdge[1]` pulses 12 times, `status[1]` stays 0 and `irq` stays 0.
- **Simultaneous set and clear:** assert `clr[2]` on the same cycle as a qualified rise on channel 2 → `status[2]` stays 1. Assert `clr[2]` again one cycle later → `status[2]`=0 and `irq`=0.
- **Filter, FILT_CNT=3, macro defined:**
  - A 2-cycle high glitch → no pulse.
  - A 3-cycle high level → one `posEdge` at E0+2+3.
- **Mid-operation reset:** assert `rst` low while `status`=4'b1011 → all outputs 0 asynchronously. After release, no pulses appear inside the arm window.
